// File: rtl/ucie_ctl_phy_csr_initiator.sv
// PHY CSR write initiator: forwards host CSR writes and runs the link-training
// kick / wait / back-off retry sequence on the same write port.
module ucie_ctl_phy_csr_initiator #(
  parameter int          TIMEOUT    = 1024,
  parameter int          MAX_RETRY  = 3,
  parameter int          BACKOFF    = 16,
  parameter logic [7:0]  TRAIN_ADDR = 8'h10,
  parameter int          START_BIT  = 10,
  localparam int         RW         = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_req_valid,
  output logic          o_req_ready,
  input  logic [7:0]    i_req_addr,
  input  logic [31:0]   i_req_wdata,
  output logic          o_req_err,
  input  logic          i_start_link,
  input  logic          i_training_done,
  output logic          o_WR,
  output logic [7:0]    o_addr,
  output logic [31:0]   o_WDATA,
  output logic          o_link_up,
  output logic          o_link_fail,
  output logic [RW-1:0] o_retry_cnt
);

  localparam int          CMAX       = (TIMEOUT > BACKOFF) ? TIMEOUT : BACKOFF;
  localparam int          CW         = $clog2(CMAX + 1);
  localparam logic [31:0] START_MASK = 32'(1) << START_BIT;

  typedef enum logic [2:0] {S_IDLE, S_PASS, S_KICK, S_WAIT, S_BACKOFF} state_e;

  state_e        state_q;
  logic          wr_q, err_q, up_q, fail_q;
  logic [7:0]    addr_q;
  logic [31:0]   wdata_q, shadow_q;
  logic [RW-1:0] retry_q;
  logic [CW-1:0] cnt_q;

  assign o_req_ready = (state_q == S_IDLE) && !i_start_link;
  assign o_WR        = wr_q;
  assign o_addr      = addr_q;
  assign o_WDATA     = wdata_q;
  assign o_req_err   = err_q;
  assign o_link_up   = up_q;
  assign o_link_fail = fail_q;
  assign o_retry_cnt = retry_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      wr_q     <= 1'b0;
      err_q    <= 1'b0;
      up_q     <= 1'b0;
      fail_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      shadow_q <= '0;
      retry_q  <= '0;
      cnt_q    <= '0;
    end else begin
      wr_q  <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start_link) begin
            up_q    <= 1'b0;
            fail_q  <= 1'b0;
            retry_q <= '0;
            cnt_q   <= '0;
            wr_q    <= 1'b1;
            addr_q  <= TRAIN_ADDR;
            wdata_q <= shadow_q | START_MASK;
            state_q <= S_KICK;
          end else if (i_req_valid) begin
            if (i_req_addr[1:0] == 2'b00) begin
              wr_q    <= 1'b1;
              addr_q  <= i_req_addr;
              wdata_q <= i_req_wdata;
              if (i_req_addr == TRAIN_ADDR) shadow_q <= i_req_wdata & ~START_MASK;
              state_q <= S_PASS;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        S_PASS: state_q <= S_IDLE;
        // The KICK write cycle is the first of the TIMEOUT cycles of an attempt.
        S_KICK: begin
          cnt_q   <= CW'(1);
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (i_training_done) begin
            up_q    <= 1'b1;
            state_q <= S_IDLE;
          end else if (cnt_q == CW'(TIMEOUT - 1)) begin
            if (retry_q == RW'(MAX_RETRY)) begin
              fail_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              retry_q <= retry_q + RW'(1);
              cnt_q   <= '0;
              state_q <= S_BACKOFF;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_BACKOFF: begin
          if (cnt_q == CW'(BACKOFF - 1)) begin
            cnt_q   <= '0;
            wr_q    <= 1'b1;
            addr_q  <= TRAIN_ADDR;
            wdata_q <= shadow_q | START_MASK;
            state_q <= S_KICK;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
